serial_adder: RTL
=================

# serial_adder

Bit-serial, LSB-first N-bit adder built around the existing single-bit `full_adder` cell, with a registered carry between steps. It sits directly downstream of `full_adder`: it consumes the cell's `final_sum` and `final_carry` once per clock and accumulates them into a full-width result. Operands are captured on a start pulse. The result is delivered with a one-cycle `done` strobe after WIDTH bit-steps. It trades area for latency in datapaths where one full adder is enough.

## Interface
- `WIDTH`, default 8, operand/result width in bits; legal range 1 to 64.
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  request; sampled only in IDLE or DONE.
- `a`  in  WIDTH  operand A; captured on an accepted `start`.
- `b`  in  WIDTH  operand B; captured on an accepted `start`.
- `cin`  in  1  carry-in; captured on an accepted `start`.
- `busy`  out  1  high while in RUN.
- `done`  out  1  one-cycle strobe; `sum` and `cout` are valid from this cycle.
- `sum`  out  WIDTH  result register; holds until the next `done`.
- `cout`  out  1  carry-out register; holds with `sum`.

## Operation
- States: IDLE, RUN, DONE.
- IDLE -> RUN on `start`:
  - load the A and B shift registers from `a` and `b`;
  - load the carry flop from `cin`;
  - clear the bit counter and the internal sum shift register.
- RUN, each cycle:
  - `full_adder` is driven with A_sr[0], B_sr[0] and the carry flop;
  - shift A_sr and B_sr right by one;
  - shift `final_sum` into the sum shift register at the MSB (right-shift);
  - carry flop <= `final_carry`;
  - counter increments.
- RUN -> DONE on the step where the counter equals WIDTH-1. On that same edge:
  - `sum` <= completed shift register, i.e. the final `final_sum` concatenated with the upper WIDTH-1 bits already accumulated;
  - `cout` <= `final_carry`.
- DONE lasts exactly one cycle with `done`=1.
  - With `start`=1: accept new operands and go to RUN (back-to-back).
  - Otherwise: go to IDLE.
- `start` during RUN is ignored. Operands are not re-sampled and the result is unaffected.
- Arithmetic: {cout, sum} = a + b + cin, computed modulo 2^(WIDTH+1). No overflow flag.
- Output reset values (after any `rst` edge):
  - state IDLE; `busy` 0, `done` 0, `sum` 0, `cout` 0;
  - counter, carry flop and all shift registers 0.
- `rst` mid-RUN aborts the operation. No `done` is produced and the outputs return to their reset values.
- `rst` has priority over `start` in the same cycle.
- WIDTH=1: RUN lasts exactly one cycle. The counter is held at its minimum width of 1 bit.

## Timing
- Edge E0 samples `start` (state IDLE or DONE). RUN then occupies the cycles following edges E0 through E(WIDTH-1).
- `busy` is high exactly WIDTH cycles.
- At edge E(WIDTH), state becomes DONE. `done` is high for the one cycle following that edge, so latency is WIDTH cycles from the edge that samples `start`.
- Maximum throughput: one operation per WIDTH+1 cycles, with `start` held high through DONE.
- `sum` and `cout` change only at the DONE entry edge and at reset. They are stable at every other time, including throughout the next RUN.
- All outputs come directly from flops; there is no combinational input-to-output path.
- The `full_adder` path (A_sr[0], B_sr[0], carry flop -> carry flop and sum shift register) is the only combinational stage per cycle.

## Structure
- `serial_adder_pkg` contains:
  - the `state_t` enum {IDLE, RUN, DONE};
  - a function `cnt_w(width)` returning max(1, $clog2(width)) for the counter width.
- Exactly one sub-module: the existing `full_adder` instance (`a`, `b`, `cin`, `final_sum`, `final_carry`). Do not inline the adder logic.
- The remaining logic (FSM, counter, shift registers, output registers) is local to `serial_adder`.

## Test plan
All scenarios use WIDTH=8.
- Reset, then `start` with a=8'h00, b=8'h00, cin=0 -> `busy` high for 8 cycles; `done` pulses for exactly 1 cycle, 8 cycles after the start edge; sum=8'h00, cout=0.
- a=8'hFF, b=8'h01, cin=0 -> sum=8'h00, cout=1. Then a=8'h3C, b=8'h42, cin=1 -> sum=8'h7F, cout=0.
- Start a=8'hA5, b=8'h5A, cin=1; pulse `start` with a=8'h01, b=8'h01 on RUN cycle 3 -> a single `done`; sum=8'h00, cout=1 (first operation only).
- Start an operation, then assert `rst` for one cycle on RUN cycle 4 -> next cycle `busy`=0, `done` never asserts, sum=0, cout=0. A fresh start with a=8'h10, b=8'h20, cin=0 -> sum=8'h30, cout=0.
- Hold `start` high through DONE with new operands a=8'h80, b=8'h80, cin=0 -> two `done` pulses exactly 9 cycles apart; second result sum=8'h00, cout=1; `busy` low only during the DONE cycle.
- Random loop of 1000 operands -> {cout, sum} matches a+b+cin on every `done`; `sum` never changes outside DONE entry.

Source files
------------

// File: rtl/serial_adder_pkg.sv
// rtl/serial_adder_pkg.sv - shared types and sizing helper for the bit-serial adder
package serial_adder_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Step counter width; never narrower than one bit so WIDTH=1 still has a counter.
    function automatic int cnt_w(input int width);
        int w;
        w = $clog2(width);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/full_adder.sv
// rtl/full_adder.sv - single-bit full adder cell
module full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic final_sum,
    output logic final_carry
);

    assign final_sum   = a ^ b ^ cin;
    assign final_carry = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/serial_adder.sv
// rtl/serial_adder.sv - LSB-first bit-serial adder around one full_adder cell
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int            CW   = cnt_w(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    state_t           state;
    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic [WIDTH-1:0] s_sr;
    logic [WIDTH-1:0] s_next;
    logic             carry;
    logic [CW-1:0]    cnt;
    logic             fa_sum;
    logic             fa_carry;

    full_adder u_full_adder (
        .a           (a_sr[0]),
        .b           (b_sr[0]),
        .cin         (carry),
        .final_sum   (fa_sum),
        .final_carry (fa_carry)
    );

    // New sum bit enters at the MSB; the concatenate-then-shift form also covers WIDTH=1.
    assign s_next = WIDTH'({fa_sum, s_sr} >> 1);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            a_sr  <= '0;
            b_sr  <= '0;
            s_sr  <= '0;
            carry <= 1'b0;
            cnt   <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
            sum   <= '0;
            cout  <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        a_sr  <= a;
                        b_sr  <= b;
                        s_sr  <= '0;
                        carry <= cin;
                        cnt   <= '0;
                        busy  <= 1'b1;
                        state <= RUN;
                    end else begin
                        state <= IDLE;
                    end
                end
                RUN: begin
                    a_sr  <= a_sr >> 1;
                    b_sr  <= b_sr >> 1;
                    s_sr  <= s_next;
                    carry <= fa_carry;
                    cnt   <= cnt + 1'b1;
                    if (cnt == LAST) begin
                        sum   <= s_next;
                        cout  <= fa_carry;
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        state <= DONE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
